// File: rtl/liang_pkg.sv
// Shared types for the multi-cycle execution sequencer: FSM states and fault causes.
package liang_pkg;

    typedef enum logic [2:0] {
        ST_FETCH    = 3'd0,
        ST_IF_WAIT  = 3'd1,
        ST_DECODE   = 3'd2,
        ST_MEM_REQ  = 3'd3,
        ST_MEM_WAIT = 3'd4,
        ST_WB       = 3'd5,
        ST_HALT     = 3'd6,
        ST_FAULT    = 3'd7
    } seq_state_e;

    typedef enum logic [1:0] {
        FC_NONE    = 2'd0,
        FC_IFETCH  = 2'd1,
        FC_LSU     = 2'd2,
        FC_TIMEOUT = 2'd3
    } fault_cause_e;

    // States in which the sequencer is waiting on the bus and the watchdog runs
    function automatic logic is_wait_state(input seq_state_e s);
        return (s == ST_FETCH) || (s == ST_IF_WAIT) || (s == ST_MEM_REQ) || (s == ST_MEM_WAIT);
    endfunction

endpackage

// File: rtl/seq_timeout_cnt.sv
// Watchdog counter for bus wait states: counts enabled cycles since the last clear and
// flags when the count reaches TIMEOUT_CYCLES (never, when TIMEOUT_CYCLES is 0).
module seq_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int TO_W           = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT_CYCLES);

    logic [TO_W-1:0] count_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr) begin
            count_reg <= '0;
        end else if (en && !expired) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    generate
        if (TIMEOUT_CYCLES == 0) begin : gen_disabled
            assign expired = 1'b0;
        end else begin : gen_enabled
            assign expired = (count_reg == LIMIT);
        end
    endgenerate

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle control FSM for the RV core: sequences fetch, decode, optional load/store and
// writeback, counts retired instructions, and stops on ebreak, bus error or bus timeout.
module exec_sequencer
    import liang_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int TO_W           = 10
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        if_req_valid_o,
    input  logic        if_req_ready_i,
    input  logic        if_rsp_valid_i,
    input  logic        if_rsp_err_i,
    output logic        inst_latch_o,
    input  logic        is_load_i,
    input  logic        is_store_i,
    input  logic        ebreak_i,
    input  logic        rd_wen_i,
    output logic        lsu_req_valid_o,
    output logic        lsu_req_we_o,
    input  logic        lsu_req_ready_i,
    input  logic        lsu_rsp_valid_i,
    input  logic        lsu_rsp_err_i,
    output logic        rf_wen_o,
    output logic        pc_we_o,
    output logic        halted_o,
    output logic        fault_o,
    output logic [1:0]  fault_cause_o,
    output logic [63:0] retire_cnt_o
);

    seq_state_e   state_reg, state_next;
    fault_cause_e cause_reg, cause_next;
    logic         store_reg, store_next;
    logic [63:0]  retire_reg;
    logic         to_expired;

    seq_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TO_W          (TO_W)
    ) u_timeout (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr    (state_next != state_reg),
        .en     (is_wait_state(state_reg)),
        .expired(to_expired)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg  <= ST_FETCH;
            cause_reg  <= FC_NONE;
            store_reg  <= 1'b0;
            retire_reg <= '0;
        end else begin
            state_reg <= state_next;
            cause_reg <= cause_next;
            store_reg <= store_next;
            if (state_reg == ST_WB) begin
                retire_reg <= retire_reg + 64'd1;
            end
        end
    end

    // Handshakes and responses are tested before the watchdog so they win a same-cycle tie
    always_comb begin
        state_next = state_reg;
        cause_next = cause_reg;
        store_next = store_reg;
        case (state_reg)
            ST_FETCH: begin
                if (if_req_ready_i) begin
                    state_next = ST_IF_WAIT;
                end else if (to_expired) begin
                    state_next = ST_FAULT;
                    cause_next = FC_TIMEOUT;
                end
            end
            ST_IF_WAIT: begin
                if (if_rsp_valid_i) begin
                    if (if_rsp_err_i) begin
                        state_next = ST_FAULT;
                        cause_next = FC_IFETCH;
                    end else begin
                        state_next = ST_DECODE;
                    end
                end else if (to_expired) begin
                    state_next = ST_FAULT;
                    cause_next = FC_TIMEOUT;
                end
            end
            ST_DECODE: begin
                if (ebreak_i) begin
                    state_next = ST_HALT;
                end else begin
                    store_next = is_store_i;
                    state_next = (is_load_i || is_store_i) ? ST_MEM_REQ : ST_WB;
                end
            end
            ST_MEM_REQ: begin
                if (lsu_req_ready_i) begin
                    state_next = ST_MEM_WAIT;
                end else if (to_expired) begin
                    state_next = ST_FAULT;
                    cause_next = FC_TIMEOUT;
                end
            end
            ST_MEM_WAIT: begin
                if (lsu_rsp_valid_i) begin
                    if (lsu_rsp_err_i) begin
                        state_next = ST_FAULT;
                        cause_next = FC_LSU;
                    end else begin
                        state_next = ST_WB;
                    end
                end else if (to_expired) begin
                    state_next = ST_FAULT;
                    cause_next = FC_TIMEOUT;
                end
            end
            ST_WB:    state_next = ST_FETCH;
            ST_HALT:  state_next = ST_HALT;
            ST_FAULT: state_next = ST_FAULT;
            default:  state_next = ST_FETCH;
        endcase
    end

    assign if_req_valid_o  = (state_reg == ST_FETCH);
    assign inst_latch_o    = (state_reg == ST_IF_WAIT) && if_rsp_valid_i && !if_rsp_err_i;
    assign lsu_req_valid_o = (state_reg == ST_MEM_REQ);
    assign lsu_req_we_o    = (state_reg == ST_MEM_REQ) && store_reg;
    assign rf_wen_o        = (state_reg == ST_WB) && rd_wen_i && !store_reg;
    assign pc_we_o         = (state_reg == ST_WB);
    assign halted_o        = (state_reg == ST_HALT);
    assign fault_o         = (state_reg == ST_FAULT);
    assign fault_cause_o   = cause_reg;
    assign retire_cnt_o    = retire_reg;

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: a responsive bus/decoder model drives instructions and the
// outcome of each is compared with a phase-by-phase cycle budget computed in the bench.
module tb_exec_sequencer;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        if_req_valid_o, if_req_ready_i = 0, if_rsp_valid_i = 0, if_rsp_err_i = 0;
    logic        inst_latch_o, is_load_i = 0, is_store_i = 0, ebreak_i = 0, rd_wen_i = 0;
    logic        lsu_req_valid_o, lsu_req_we_o, lsu_req_ready_i = 0, lsu_rsp_valid_i = 0, lsu_rsp_err_i = 0;
    logic        rf_wen_o, pc_we_o, halted_o, fault_o;
    logic [1:0]  fault_cause_o;
    logic [63:0] retire_cnt_o;

    int checks = 0;
    int errors = 0;
    longint unsigned retire_model = 0;

    always #5 clk = ~clk;

    exec_sequencer #(.TIMEOUT_CYCLES(T), .TO_W(4)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .if_req_valid_o(if_req_valid_o), .if_req_ready_i(if_req_ready_i),
        .if_rsp_valid_i(if_rsp_valid_i), .if_rsp_err_i(if_rsp_err_i),
        .inst_latch_o(inst_latch_o),
        .is_load_i(is_load_i), .is_store_i(is_store_i), .ebreak_i(ebreak_i), .rd_wen_i(rd_wen_i),
        .lsu_req_valid_o(lsu_req_valid_o), .lsu_req_we_o(lsu_req_we_o), .lsu_req_ready_i(lsu_req_ready_i),
        .lsu_rsp_valid_i(lsu_rsp_valid_i), .lsu_rsp_err_i(lsu_rsp_err_i),
        .rf_wen_o(rf_wen_o), .pc_we_o(pc_we_o), .halted_o(halted_o), .fault_o(fault_o),
        .fault_cause_o(fault_cause_o), .retire_cnt_o(retire_cnt_o)
    );

    // Expected outcome from per-phase wait budgets: kind 0 alu, 1 load, 2 store, 3 ebreak.
    // Result: cycle (1-based from instruction start) of pc_we / halted / fault, end kind 0/1/2, cause.
    task automatic model_instr(input int kind, input int ir, input int is_, input int lr, input int ls,
                               input bit ie, input bit le,
                               output int ecyc, output int ekind, output int ecause);
        int t = 0;
        ecyc = 0; ekind = 2; ecause = 3;
        if (ir > T) begin ecyc = t + T + 2; return; end
        t += ir + 1;
        if (is_ > T) begin ecyc = t + T + 2; return; end
        t += is_ + 1;
        if (ie) begin ecyc = t + 1; ecause = 1; return; end
        t += 1;
        if (kind == 3) begin ecyc = t + 1; ekind = 1; ecause = 0; return; end
        if (kind == 1 || kind == 2) begin
            if (lr > T) begin ecyc = t + T + 2; return; end
            t += lr + 1;
            if (ls > T) begin ecyc = t + T + 2; return; end
            t += ls + 1;
            if (le) begin ecyc = t + 1; ecause = 2; return; end
        end
        ecyc = t + 1; ekind = 0; ecause = 0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_i = 1'b1;
        {if_req_ready_i, if_rsp_valid_i, if_rsp_err_i, lsu_req_ready_i, lsu_rsp_valid_i, lsu_rsp_err_i} = '0;
        {is_load_i, is_store_i, ebreak_i, rd_wen_i} = '0;
        @(negedge clk);
        rst_i = 1'b0;
        retire_model = 0;
    endtask

    // Drives one instruction cycle by cycle, starting in the current cycle; returns observations
    task automatic run_instr(input int kind, input bit rdw, input int ir, input int is_, input int lr,
                             input int ls, input bit ie, input bit le,
                             output int end_cyc, output int end_kind, output bit rf_obs,
                             output int rf_pulses, output int latch_pulses, output bit lsu_we_obs,
                             output int if_vc, output int lsu_vc);
        int if_rsp_at = -1;
        int lsu_rsp_at = -1;
        is_load_i = (kind == 1); is_store_i = (kind == 2); ebreak_i = (kind == 3); rd_wen_i = rdw;
        end_cyc = 0; end_kind = 3; rf_obs = 0; rf_pulses = 0; latch_pulses = 0;
        lsu_we_obs = 0; if_vc = 0; lsu_vc = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if_req_ready_i = 0; if_rsp_valid_i = 0; if_rsp_err_i = 1'($urandom);
            lsu_req_ready_i = 0; lsu_rsp_valid_i = 0; lsu_rsp_err_i = 1'($urandom);
            if (if_req_valid_o) begin
                if_req_ready_i = (if_vc == ir);
                if_vc++;
                if (if_req_ready_i) if_rsp_at = cyc + 1 + is_;
            end
            if (cyc == if_rsp_at) begin if_rsp_valid_i = 1; if_rsp_err_i = ie; end
            if (lsu_req_valid_o) begin
                lsu_we_obs = lsu_req_we_o;
                lsu_req_ready_i = (lsu_vc == lr);
                lsu_vc++;
                if (lsu_req_ready_i) lsu_rsp_at = cyc + 1 + ls;
            end
            if (cyc == lsu_rsp_at) begin lsu_rsp_valid_i = 1; lsu_rsp_err_i = le; end
            #1;
            if (inst_latch_o) latch_pulses++;
            if (rf_wen_o) rf_pulses++;
            if (halted_o || fault_o) begin
                end_cyc = cyc; end_kind = halted_o ? 1 : 2;
                break;
            end
            if (pc_we_o) begin
                end_cyc = cyc; end_kind = 0; rf_obs = rf_wen_o;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        do_reset();
        #1;
        checks++;
        if ({halted_o, fault_o, fault_cause_o, lsu_req_valid_o, lsu_req_we_o, pc_we_o, rf_wen_o, inst_latch_o} !== '0) begin
            errors++; $display("FAIL reset_outputs: got %b required 0", {halted_o, fault_o, fault_cause_o, lsu_req_valid_o, lsu_req_we_o, pc_we_o, rf_wen_o, inst_latch_o});
        end
        checks++;
        if (retire_cnt_o !== 64'd0) begin errors++; $display("FAIL reset_retire: got %0d required 0", retire_cnt_o); end
        checks++;
        if (if_req_valid_o !== 1'b1) begin errors++; $display("FAIL reset_fetch_valid: got %b required 1", if_req_valid_o); end
        $display("reset: retire=%0d if_req_valid=%b", retire_cnt_o, if_req_valid_o);
    endtask

    task automatic test_add;
        int ec, ek, rp, lp, ivc, lvc; bit rf, we;
        run_instr(0, 1, 0, 0, 0, 0, 0, 0, ec, ek, rf, rp, lp, we, ivc, lvc);
        retire_model++;
        checks++;
        if (ek != 0 || ec != 4) begin errors++; $display("FAIL add_latency: got kind %0d cycle %0d required kind 0 cycle 4", ek, ec); end
        checks++;
        if (rf !== 1'b1 || lp != 1) begin errors++; $display("FAIL add_rf_latch: got rf %b latch %0d required 1 1", rf, lp); end
        checks++;
        if (retire_cnt_o !== retire_model) begin errors++; $display("FAIL add_retire: got %0d required %0d", retire_cnt_o, retire_model); end
        $display("add: pc_we at cycle %0d retire=%0d", ec, retire_cnt_o);
    endtask

    task automatic test_lw;
        int ec, ek, rp, lp, ivc, lvc; bit rf, we;
        run_instr(1, 1, 0, 0, 3, 0, 0, 0, ec, ek, rf, rp, lp, we, ivc, lvc);
        retire_model++;
        checks++;
        if (ek != 0 || ec != 9) begin errors++; $display("FAIL lw_latency: got kind %0d cycle %0d required kind 0 cycle 9", ek, ec); end
        checks++;
        if (lvc != 4 || we !== 1'b0) begin errors++; $display("FAIL lw_req: got valid cycles %0d we %b required 4 0", lvc, we); end
        checks++;
        if (rp != 1 || rf !== 1'b1) begin errors++; $display("FAIL lw_rf_wen: got pulses %0d in_wb %b required 1 1", rp, rf); end
        checks++;
        if (retire_cnt_o !== retire_model) begin errors++; $display("FAIL lw_retire: got %0d required %0d", retire_cnt_o, retire_model); end
        $display("lw: pc_we at cycle %0d lsu valid cycles %0d", ec, lvc);
    endtask

    task automatic test_sw;
        int ec, ek, rp, lp, ivc, lvc; bit rf, we;
        run_instr(2, 1, 0, 0, 0, 0, 0, 0, ec, ek, rf, rp, lp, we, ivc, lvc);
        retire_model++;
        checks++;
        if (ek != 0 || ec != 6) begin errors++; $display("FAIL sw_latency: got kind %0d cycle %0d required kind 0 cycle 6", ek, ec); end
        checks++;
        if (we !== 1'b1 || rp != 0) begin errors++; $display("FAIL sw_we_rf: got we %b rf pulses %0d required 1 0", we, rp); end
        checks++;
        if (retire_cnt_o !== retire_model) begin errors++; $display("FAIL sw_retire: got %0d required %0d", retire_cnt_o, retire_model); end
        $display("sw: pc_we at cycle %0d we=%b retire=%0d", ec, we, retire_cnt_o);
    endtask

    task automatic test_fetch_err;
        int ec, ek, rp, lp, ivc, lvc, bad; bit rf, we;
        bad = 0;
        run_instr(0, 1, 0, 0, 0, 0, 1, 0, ec, ek, rf, rp, lp, we, ivc, lvc);
        checks++;
        if (ek != 2 || ec != 3 || fault_cause_o !== 2'd1) begin
            errors++; $display("FAIL fetch_err: got kind %0d cycle %0d cause %0d required 2 3 1", ek, ec, fault_cause_o);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            {if_req_ready_i, if_rsp_valid_i, if_rsp_err_i, lsu_req_ready_i, lsu_rsp_valid_i, lsu_rsp_err_i} = 6'($urandom);
            #1;
            if (inst_latch_o) lp++;
            if (if_req_valid_o || lsu_req_valid_o || pc_we_o || rf_wen_o || !fault_o || fault_cause_o !== 2'd1) bad++;
        end
        checks++;
        if (bad != 0 || lp != 0) begin errors++; $display("FAIL fault_hold: got %0d bad cycles %0d latches required 0 0", bad, lp); end
        $display("fetch_err: fault at cycle %0d cause %0d", ec, fault_cause_o);
        do_reset();
    endtask

    task automatic test_timeout;
        int ec, ek, rp, lp, ivc, lvc; bit rf, we;
        run_instr(0, 0, T + 1, 0, 0, 0, 0, 0, ec, ek, rf, rp, lp, we, ivc, lvc);
        checks++;
        if (ek != 2 || ec != T + 2 || fault_cause_o !== 2'd3) begin
            errors++; $display("FAIL timeout_fault: got kind %0d cycle %0d cause %0d required 2 %0d 3", ek, ec, fault_cause_o, T + 2);
        end
        $display("timeout: fault at cycle %0d cause %0d", ec, fault_cause_o);
        do_reset();
        run_instr(0, 0, T, 0, 0, 0, 0, 0, ec, ek, rf, rp, lp, we, ivc, lvc);
        retire_model++;
        checks++;
        if (ek != 0 || ec != T + 4) begin errors++; $display("FAIL timeout_edge: got kind %0d cycle %0d required 0 %0d", ek, ec, T + 4); end
        $display("timeout_edge: pc_we at cycle %0d", ec);
    endtask

    task automatic test_ebreak;
        int ec, ek, rp, lp, ivc, lvc, bad; bit rf, we;
        bad = 0;
        run_instr(0, 1, 1, 1, 0, 0, 0, 0, ec, ek, rf, rp, lp, we, ivc, lvc);
        retire_model++;
        run_instr(3, 1, 0, 0, 0, 0, 0, 0, ec, ek, rf, rp, lp, we, ivc, lvc);
        checks++;
        if (ek != 1 || ec != 4) begin errors++; $display("FAIL ebreak_halt: got kind %0d cycle %0d required 1 4", ek, ec); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            {if_req_ready_i, if_rsp_valid_i, lsu_req_ready_i, lsu_rsp_valid_i} = 4'($urandom);
            #1;
            if (if_req_valid_o || lsu_req_valid_o || pc_we_o || rf_wen_o || inst_latch_o || !halted_o || fault_o) bad++;
            if (retire_cnt_o !== retire_model) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL halt_hold: got %0d bad cycles required 0", bad); end
        $display("ebreak: halted at cycle %0d retire=%0d", ec, retire_cnt_o);
        test_reset();
    endtask

    function automatic int rnd_dly();
        if ($urandom_range(7) == 0) return int'($urandom_range(T + 2, T - 1));
        return int'($urandom_range(3));
    endfunction

    task automatic test_random;
        int kind, ir, is_, lr, ls, ec, ek, rp, lp, ivc, lvc, mc, mk, mcause;
        bit rdw, ie, le, rf, we;
        for (int n = 0; n < 150; n++) begin
            kind = ($urandom_range(9) == 0) ? 3 : int'($urandom_range(2));
            rdw = 1'($urandom);
            ir = rnd_dly(); is_ = rnd_dly(); lr = rnd_dly(); ls = rnd_dly();
            ie = ($urandom_range(15) == 0); le = ($urandom_range(15) == 0);
            model_instr(kind, ir, is_, lr, ls, ie, le, mc, mk, mcause);
            run_instr(kind, rdw, ir, is_, lr, ls, ie, le, ec, ek, rf, rp, lp, we, ivc, lvc);
            checks++;
            if (ec != mc || ek != mk) begin
                errors++; $display("FAIL rand_outcome #%0d: got kind %0d cycle %0d required kind %0d cycle %0d", n, ek, ec, mk, mc);
            end
            if (mk == 0) begin
                retire_model++;
                checks++;
                if (rf !== (rdw && kind != 2) || retire_cnt_o !== retire_model || (kind != 0 && we !== (kind == 2))) begin
                    errors++; $display("FAIL rand_retire #%0d: got rf %b we %b retire %0d required rf %b we %b retire %0d",
                                       n, rf, we, retire_cnt_o, rdw && kind != 2, kind == 2, retire_model);
                end
            end else begin
                checks++;
                if (fault_cause_o !== 2'(mcause) || retire_cnt_o !== retire_model) begin
                    errors++; $display("FAIL rand_stop #%0d: got cause %0d retire %0d required cause %0d retire %0d", n, fault_cause_o, retire_cnt_o, mcause, retire_model);
                end
                do_reset();
            end
            $display("rand #%0d kind %0d delays %0d/%0d/%0d/%0d err %b%b: end kind %0d at cycle %0d", n, kind, ir, is_, lr, ls, ie, le, ek, ec);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw();
        test_sw();
        test_fetch_err();
        test_timeout();
        test_ebreak();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
